// File: rtl/cosim_retire_buf.sv
// cosim_retire_buf
//   Collects per-cycle retirement records (pc, ir, privilege, GPR write, trap)
//   from a multi-retire commit stage. It serialises them in program order
//   through a FIFO toward a one-instruction-per-step cosim checker.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   flush             synchronous clear of FIFO contents and overflow flag
//   ret_*             RET_W retire slots, flattened slot-major (slot 0 in LSBs)
//   in_ready          at least RET_W free entries (from registered count)
//   out_valid/ready   head record handshake toward the checker
//   out_*             head record fields, forced to 0 while out_valid=0
//   out_seq           retire sequence number of the head record
//   count             occupied entries
//   overflow          sticky: a whole retire group was dropped for lack of space
//   proto_err         sticky: ret_valid was not compacted toward slot 0

module cosim_retire_buf #(
    parameter int unsigned RET_W = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned XLEN  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [RET_W-1:0]             ret_valid,
    input  logic [RET_W*XLEN-1:0]        ret_pc,
    input  logic [RET_W*32-1:0]          ret_ir,
    input  logic [RET_W*2-1:0]           ret_prv,
    input  logic [RET_W-1:0]             ret_rd_we,
    input  logic [RET_W*5-1:0]           ret_rd,
    input  logic [RET_W*XLEN-1:0]        ret_rd_data,
    input  logic [RET_W-1:0]             ret_trap,
    input  logic [RET_W*8-1:0]           ret_cause,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [31:0]                  out_ir,
    output logic [1:0]                   out_prv,
    output logic                         out_rd_we,
    output logic [4:0]                   out_rd,
    output logic [XLEN-1:0]              out_rd_data,
    output logic                         out_trap,
    output logic [7:0]                   out_cause,
    output logic [31:0]                  out_seq,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         proto_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Record storage, one array per field
    logic [XLEN-1:0] mem_pc      [DEPTH];
    logic [31:0]     mem_ir      [DEPTH];
    logic [1:0]      mem_prv     [DEPTH];
    logic            mem_rd_we   [DEPTH];
    logic [4:0]      mem_rd      [DEPTH];
    logic [XLEN-1:0] mem_rd_data [DEPTH];
    logic            mem_trap    [DEPTH];
    logic [7:0]      mem_cause   [DEPTH];
    logic [31:0]     mem_seq     [DEPTH];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [31:0]     seq_ctr;

    logic [CW-1:0]   nvalid;
    logic [CW-1:0]   slot_off [RET_W];
    logic [AW-1:0]   wr_idx   [RET_W];
    logic [AW-1:0]   rd_idx;
    logic [CW-1:0]   free_cnt;
    logic            gap;
    logic            push_ok;
    logic            drop;
    logic            pop;

    // Each valid slot lands at wr_ptr + (number of valid slots below it), so
    // a non-compacted group is still packed densely in slot order.
    always_comb begin
        nvalid = '0;
        for (int unsigned i = 0; i < RET_W; i++) begin
            slot_off[i] = nvalid;
            if (ret_valid[i]) nvalid = nvalid + CW'(1);
        end
    end

    always_comb begin
        gap = 1'b0;
        for (int unsigned i = 1; i < RET_W; i++) begin
            if (ret_valid[i] && !ret_valid[i-1]) gap = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < RET_W; i++) begin
            wr_idx[i] = wr_ptr[AW-1:0] + slot_off[i][AW-1:0];
        end
    end

    assign rd_idx    = rd_ptr[AW-1:0];
    assign free_cnt  = CW'(DEPTH) - count;
    assign out_valid = (count != '0);
    assign in_ready  = (free_cnt >= CW'(RET_W));

    // All-or-nothing push against the registered free count; a pop in the
    // same cycle does not make room for this cycle's group.
    assign push_ok = !flush && (nvalid != '0) && (nvalid <= free_cnt);
    assign drop    = !flush && (nvalid > free_cnt);
    assign pop     = !flush && out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            seq_ctr   <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else if (flush) begin
            // Sequence numbering and protocol history survive a flush.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(nvalid);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            count <= count + (push_ok ? nvalid : '0) - (pop ? CW'(1) : '0);
            // Dropped groups still consume sequence numbers so gaps are visible.
            seq_ctr <= seq_ctr + 32'(nvalid);
            if (drop) overflow  <= 1'b1;
            if (gap)  proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < RET_W; i++) begin
            if (push_ok && ret_valid[i]) begin
                mem_pc[wr_idx[i]]      <= ret_pc[i*XLEN +: XLEN];
                mem_ir[wr_idx[i]]      <= ret_ir[i*32 +: 32];
                mem_prv[wr_idx[i]]     <= ret_prv[i*2 +: 2];
                // x0 writes and trapped instructions carry no architectural write
                mem_rd_we[wr_idx[i]]   <= ret_rd_we[i] && (ret_rd[i*5 +: 5] != 5'd0)
                                          && !ret_trap[i];
                mem_rd[wr_idx[i]]      <= ret_rd[i*5 +: 5];
                mem_rd_data[wr_idx[i]] <= ret_rd_data[i*XLEN +: XLEN];
                mem_trap[wr_idx[i]]    <= ret_trap[i];
                mem_cause[wr_idx[i]]   <= ret_cause[i*8 +: 8];
                mem_seq[wr_idx[i]]     <= seq_ctr + 32'(slot_off[i]);
            end
        end
    end

    assign out_pc      = out_valid ? mem_pc[rd_idx]      : '0;
    assign out_ir      = out_valid ? mem_ir[rd_idx]      : '0;
    assign out_prv     = out_valid ? mem_prv[rd_idx]     : '0;
    assign out_rd_we   = out_valid ? mem_rd_we[rd_idx]   : 1'b0;
    assign out_rd      = out_valid ? mem_rd[rd_idx]      : '0;
    assign out_rd_data = out_valid ? mem_rd_data[rd_idx] : '0;
    assign out_trap    = out_valid ? mem_trap[rd_idx]    : 1'b0;
    assign out_cause   = out_valid ? mem_cause[rd_idx]   : '0;
    assign out_seq     = out_valid ? mem_seq[rd_idx]     : '0;

endmodule

// File: tb/tb_cosim_retire_buf.sv
module tb_cosim_retire_buf;

    localparam int unsigned RET_W = 2;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned XLEN  = 64;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  flush = 1'b0;
    logic [RET_W-1:0]      ret_valid = '0;
    logic [RET_W*XLEN-1:0] ret_pc = '0;
    logic [RET_W*32-1:0]   ret_ir = '0;
    logic [RET_W*2-1:0]    ret_prv = '0;
    logic [RET_W-1:0]      ret_rd_we = '0;
    logic [RET_W*5-1:0]    ret_rd = '0;
    logic [RET_W*XLEN-1:0] ret_rd_data = '0;
    logic [RET_W-1:0]      ret_trap = '0;
    logic [RET_W*8-1:0]    ret_cause = '0;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [XLEN-1:0]       out_pc;
    logic [31:0]           out_ir;
    logic [1:0]            out_prv;
    logic                  out_rd_we;
    logic [4:0]            out_rd;
    logic [XLEN-1:0]       out_rd_data;
    logic                  out_trap;
    logic [7:0]            out_cause;
    logic [31:0]           out_seq;
    logic [4:0]            count;
    logic                  overflow;
    logic                  proto_err;

    int errors = 0;
    int checks = 0;

    cosim_retire_buf #(.RET_W(RET_W), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_ir(ret_ir), .ret_prv(ret_prv),
        .ret_rd_we(ret_rd_we), .ret_rd(ret_rd), .ret_rd_data(ret_rd_data),
        .ret_trap(ret_trap), .ret_cause(ret_cause),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ir(out_ir), .out_prv(out_prv), .out_rd_we(out_rd_we),
        .out_rd(out_rd), .out_rd_data(out_rd_data), .out_trap(out_trap),
        .out_cause(out_cause), .out_seq(out_seq), .count(count),
        .overflow(overflow), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task clear_inputs;
        ret_valid = '0; ret_pc = '0; ret_ir = '0; ret_prv = '0; ret_rd_we = '0;
        ret_rd = '0; ret_rd_data = '0; ret_trap = '0; ret_cause = '0;
        flush = 1'b0; out_ready = 1'b0;
    endtask

    task set_slot(input int s, input logic [63:0] pc, input logic [31:0] ir,
                  input logic [1:0] prv, input logic we, input logic [4:0] rd,
                  input logic [63:0] data, input logic trap, input logic [7:0] cause);
        ret_pc[s*XLEN +: XLEN]      = pc;
        ret_ir[s*32 +: 32]          = ir;
        ret_prv[s*2 +: 2]           = prv;
        ret_rd_we[s]                = we;
        ret_rd[s*5 +: 5]            = rd;
        ret_rd_data[s*XLEN +: XLEN] = data;
        ret_trap[s]                 = trap;
        ret_cause[s*8 +: 8]         = cause;
    endtask

    task apply_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task test_reset;
        apply_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (overflow !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%0b perr=%0b expected 0/0", overflow, proto_err); end
        checks++; if (out_pc !== 64'd0 || out_seq !== 32'd0) begin errors++; $display("FAIL reset_data: got pc=%0h seq=%0h expected 0/0", out_pc, out_seq); end
    endtask

    task test_single;
        apply_reset();
        set_slot(0, 64'h8000_0000, 32'h0000_0013, 2'd3, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        ret_valid = 2'b01;
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_same_cycle: got out_valid=%0b expected 0", out_valid); end
        tick();
        ret_valid = '0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
        checks++; if (out_pc !== 64'h8000_0000 || out_ir !== 32'h13) begin errors++; $display("FAIL single_data: got pc=%0h ir=%0h expected 80000000/13", out_pc, out_ir); end
        checks++; if (out_seq !== 32'd0 || out_prv !== 2'd3) begin errors++; $display("FAIL single_seq_prv: got seq=%0d prv=%0d expected 0/3", out_seq, out_prv); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d expected 1", count); end
        tick();
        checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got count=%0d valid=%0b expected 0/0", count, out_valid); end
    endtask

    task test_overflow;
        apply_reset();
        set_slot(0, 64'h100, 32'h13, 2'd0, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        set_slot(1, 64'h104, 32'h13, 2'd0, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        ret_valid = 2'b11;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++; if (count !== 5'(2*c)) begin errors++; $display("FAIL ovf_fill_count: got %0d expected %0d", count, 2*c); end
            checks++; if (in_ready !== (c < 8)) begin errors++; $display("FAIL ovf_in_ready: got %0b expected %0b at count %0d", in_ready, (c < 8), 2*c); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b expected 0", overflow); end
        tick();
        ret_valid = '0;
        checks++; if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL ovf_drop: got ovf=%0b count=%0d expected 1/16", overflow, count); end
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_seq !== 32'(k) || out_pc !== ((k % 2 == 0) ? 64'h100 : 64'h104)) begin
                errors++; $display("FAIL ovf_drain: got v=%0b seq=%0d pc=%0h expected 1/%0d/%0h", out_valid, out_seq, out_pc, k, (k % 2 == 0) ? 64'h100 : 64'h104);
            end
            tick();
        end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL ovf_empty: got %0d expected 0", count); end
        out_ready = 1'b0;
        ret_valid = 2'b11;
        tick();
        ret_valid = '0;
        checks++; if (out_seq !== 32'd18 || count !== 5'd2) begin errors++; $display("FAIL ovf_next_seq: got seq=%0d count=%0d expected 18/2", out_seq, count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
    endtask

    task test_back_to_back;
        int exp_seq;
        apply_reset();
        set_slot(0, 64'h100, 32'h13, 2'd0, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        set_slot(1, 64'h104, 32'h13, 2'd0, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        out_ready = 1'b1;
        exp_seq = 0;
        for (int c = 0; c < 40; c++) begin
            ret_valid = in_ready ? 2'b11 : 2'b00;
            if (out_valid) begin
                checks++;
                if (out_seq !== 32'(exp_seq) || out_pc !== ((exp_seq % 2 == 0) ? 64'h100 : 64'h104)) begin
                    errors++; $display("FAIL b2b_order: got seq=%0d pc=%0h expected %0d/%0h", out_seq, out_pc, exp_seq, (exp_seq % 2 == 0) ? 64'h100 : 64'h104);
                end
                exp_seq++;
            end
            checks++; if (count > 5'd15) begin errors++; $display("FAIL b2b_bound: got count=%0d expected <=15", count); end
            tick();
        end
        ret_valid = '0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %0b expected 0", overflow); end
        checks++; if (exp_seq != 39) begin errors++; $display("FAIL b2b_popped: got %0d records expected 39", exp_seq); end
    endtask

    task test_proto;
        apply_reset();
        set_slot(1, 64'h204, 32'h33, 2'd1, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        ret_valid = 2'b10;
        tick();
        ret_valid = '0;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_flag: got %0b expected 1", proto_err); end
        checks++; if (count !== 5'd1 || out_pc !== 64'h204 || out_seq !== 32'd0) begin errors++; $display("FAIL proto_push: got count=%0d pc=%0h seq=%0d expected 1/204/0", count, out_pc, out_seq); end
        tick();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %0b expected 1", proto_err); end
    endtask

    task test_rd_we;
        apply_reset();
        set_slot(0, 64'h300, 32'h13, 2'd3, 1'b1, 5'd0, 64'hdead, 1'b0, 8'd0);
        set_slot(1, 64'h304, 32'h73, 2'd3, 1'b1, 5'd5, 64'h1234, 1'b1, 8'd2);
        ret_valid = 2'b11;
        tick();
        set_slot(0, 64'h308, 32'h93, 2'd3, 1'b1, 5'd7, 64'hbeef, 1'b0, 8'd0);
        ret_valid = 2'b01;
        tick();
        ret_valid = '0;
        out_ready = 1'b1;
        checks++; if (out_rd_we !== 1'b0 || out_rd_data !== 64'hdead) begin errors++; $display("FAIL rdwe_x0: got we=%0b data=%0h expected 0/dead", out_rd_we, out_rd_data); end
        tick();
        checks++; if (out_rd_we !== 1'b0 || out_trap !== 1'b1 || out_cause !== 8'd2) begin errors++; $display("FAIL rdwe_trap: got we=%0b trap=%0b cause=%0d expected 0/1/2", out_rd_we, out_trap, out_cause); end
        tick();
        checks++; if (out_rd_we !== 1'b1 || out_rd !== 5'd7 || out_rd_data !== 64'hbeef) begin errors++; $display("FAIL rdwe_normal: got we=%0b rd=%0d data=%0h expected 1/7/beef", out_rd_we, out_rd, out_rd_data); end
        tick();
        out_ready = 1'b0;
    endtask

    task test_rst_mid;
        apply_reset();
        set_slot(0, 64'h400, 32'h13, 2'd0, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        set_slot(1, 64'h404, 32'h13, 2'd0, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        ret_valid = 2'b11;
        for (int c = 0; c < 5; c++) tick();
        ret_valid = '0;
        checks++; if (count !== 5'd10) begin errors++; $display("FAIL rstmid_fill: got %0d expected 10", count); end
        out_ready = 1'b1;
        tick();
        checks++; if (count !== 5'd9) begin errors++; $display("FAIL rstmid_pop: got %0d expected 9", count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL rstmid_async: got valid=%0b count=%0d expected 0/0", out_valid, count); end
        #1 rst = 1'b0;
        out_ready = 1'b0;
        tick();
        checks++; if (count !== 5'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after: got count=%0d in_ready=%0b expected 0/1", count, in_ready); end
    endtask

    task test_flush;
        apply_reset();
        set_slot(0, 64'h500, 32'h13, 2'd0, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        set_slot(1, 64'h504, 32'h13, 2'd0, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        ret_valid = 2'b11;
        tick();
        tick();
        ret_valid = 2'b01;
        tick();
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL flush_fill: got %0d expected 5", count); end
        ret_valid = 2'b11;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        ret_valid = '0;
        checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got count=%0d valid=%0b expected 0/0", count, out_valid); end
        set_slot(0, 64'h600, 32'h13, 2'd0, 1'b0, 5'd0, 64'd0, 1'b0, 8'd0);
        ret_valid = 2'b01;
        tick();
        ret_valid = '0;
        checks++; if (out_seq !== 32'd5 || out_pc !== 64'h600 || count !== 5'd1) begin errors++; $display("FAIL flush_seq: got seq=%0d pc=%0h count=%0d expected 5/600/1", out_seq, out_pc, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_proto();
        test_rd_we();
        test_rst_mid();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
